// File: rtl/instr_fetch.sv
// Instruction fetch unit: serves the core's pc from a one-entry buffer or from
// instruction memory over a valid/ready request and valid-only response channel.
module instr_fetch #(
  parameter int              WORD    = 32,
  parameter logic [WORD-1:0] NOP     = 32'h00000013,
  parameter int              TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] pc,
  input  logic            pc_valid,
  input  logic            flush,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] instr_addr,
  output logic            instr_valid,
  output logic            stall,
  output logic            fault,
  output logic            mem_req_valid,
  output logic [WORD-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [WORD-1:0] mem_resp_data,
  output logic [1:0]      dbg_state
);

  // Request channel: a request transfers on a cycle where mem_req_valid and
  // mem_req_ready are both high; valid and address stay stable until then.
  // Response channel: valid-only, accepted in any WAIT cycle after the handshake.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            buf_valid_q, buf_valid_d;
  logic [WORD-1:0] buf_addr_q, buf_addr_d;
  logic [WORD-1:0] buf_data_q, buf_data_d;
  logic [WORD-1:0] req_addr_q, req_addr_d;
  logic            drop_q, drop_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] instr_addr_q, instr_addr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            stall_q, stall_d;
  logic            fault_q, fault_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic [WORD-1:0] mem_req_addr_q, mem_req_addr_d;
  logic            dropping;

  always_comb begin
    state_d         = state_q;
    buf_valid_d     = buf_valid_q;
    buf_addr_d      = buf_addr_q;
    buf_data_d      = buf_data_q;
    req_addr_d      = req_addr_q;
    drop_d          = drop_q;
    cnt_d           = cnt_q;
    instr_d         = instr_q;
    instr_addr_d    = instr_addr_q;
    instr_valid_d   = 1'b0;
    stall_d         = stall_q;
    fault_d         = 1'b0;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    dropping        = drop_q | flush;

    case (state_q)
      IDLE: begin
        if (flush) begin
          buf_valid_d = 1'b0;
        end else if (pc_valid) begin
          if (pc[1:0] != 2'b00) begin
            instr_d       = NOP;
            instr_addr_d  = pc;
            instr_valid_d = 1'b1;
            fault_d       = 1'b1;
          end else if (buf_valid_q && pc == buf_addr_q) begin
            instr_d       = buf_data_q;
            instr_addr_d  = pc;
            instr_valid_d = 1'b1;
          end else begin
            req_addr_d      = pc;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = pc;
            stall_d         = 1'b1;
            state_d         = REQ;
          end
        end
      end

      REQ: begin
        if (flush) begin
          drop_d      = 1'b1;
          buf_valid_d = 1'b0;
        end
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = 8'd0;
          state_d         = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) begin
          drop_d      = 1'b1;
          buf_valid_d = 1'b0;
        end
        // A response wins over a timeout landing in the same cycle.
        if (mem_resp_valid) begin
          if (!dropping) begin
            buf_addr_d    = req_addr_q;
            buf_data_d    = mem_resp_data;
            buf_valid_d   = 1'b1;
            instr_d       = mem_resp_data;
            instr_addr_d  = req_addr_q;
            instr_valid_d = 1'b1;
          end
          drop_d  = 1'b0;
          stall_d = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          buf_valid_d = 1'b0;
          if (!dropping) begin
            instr_d       = NOP;
            instr_addr_d  = req_addr_q;
            instr_valid_d = 1'b1;
            fault_d       = 1'b1;
          end
          drop_d  = 1'b0;
          stall_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      buf_valid_q     <= 1'b0;
      buf_addr_q      <= '0;
      buf_data_q      <= '0;
      req_addr_q      <= '0;
      drop_q          <= 1'b0;
      cnt_q           <= 8'd0;
      instr_q         <= NOP;
      instr_addr_q    <= '0;
      instr_valid_q   <= 1'b0;
      stall_q         <= 1'b0;
      fault_q         <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      buf_valid_q     <= buf_valid_d;
      buf_addr_q      <= buf_addr_d;
      buf_data_q      <= buf_data_d;
      req_addr_q      <= req_addr_d;
      drop_q          <= drop_d;
      cnt_q           <= cnt_d;
      instr_q         <= instr_d;
      instr_addr_q    <= instr_addr_d;
      instr_valid_q   <= instr_valid_d;
      stall_q         <= stall_d;
      fault_q         <= fault_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  assign instr         = instr_q;
  assign instr_addr    = instr_addr_q;
  assign instr_valid   = instr_valid_q;
  assign stall         = stall_q;
  assign fault         = fault_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign dbg_state     = state_q;

endmodule
